// File: rtl/maxpool_window_ctrl.sv
// Streaming max-pool reducer: folds each WINDOW_SIZE group of float32 elements into one maximum.
// Optional fused ReLU on the emitted result when MAXPOOL_RELU_EN is defined.

module floatComp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] max_val
);

  logic b_greater;

  // Sign-magnitude ordering: +0 beats -0, and equal patterns keep a (earlier element wins).
  always_comb begin
    b_greater = 1'b0;
    if (a[WIDTH-1] != b[WIDTH-1])
      b_greater = a[WIDTH-1];
    else if (!a[WIDTH-1])
      b_greater = (b[WIDTH-2:0] > a[WIDTH-2:0]);
    else
      b_greater = (b[WIDTH-2:0] < a[WIDTH-2:0]);
  end

  assign max_val = b_greater ? b : a;

endmodule

module maxpool_window_ctrl #(
  parameter int DATA_BITS   = 32,
  parameter int WINDOW_SIZE = 4,
  parameter int CNT_BITS    = $clog2(WINDOW_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [CNT_BITS-1:0]  win_cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(WINDOW_SIZE - 1);

  state_t               state;
  logic [DATA_BITS-1:0] run_max;
  logic [DATA_BITS-1:0] cmp_max;
  logic [DATA_BITS-1:0] next_max;
  logic [DATA_BITS-1:0] result;
  logic                 accept;

  floatComp #(.WIDTH(DATA_BITS)) u_cmp (
    .a       (run_max),
    .b       (in_data),
    .max_val (cmp_max)
  );

  assign in_ready = !clear && (state == ACC || out_ready);
  assign accept   = in_valid && in_ready;

  // The first element of a window seeds the running max without a comparison.
  assign next_max = (win_cnt == '0) ? in_data : cmp_max;

`ifdef MAXPOOL_RELU_EN
  assign result = next_max[DATA_BITS-1] ? '0 : next_max;
`else
  assign result = next_max;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      win_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      run_max   <= '0;
    end else if (clear) begin
      state     <= ACC;
      win_cnt   <= '0;
      out_valid <= 1'b0;
      run_max   <= '0;
    end else begin
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ACC;
      end
      // An element accepted while leaving HOLD starts the next window at win_cnt 0.
      if (accept) begin
        run_max <= next_max;
        if (win_cnt == LAST_IDX) begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= HOLD;
          win_cnt   <= '0;
        end else begin
          win_cnt <= win_cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule
